// File: rtl/d_down_counter.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Optional auto-reload of the last loaded value is enabled by defining DOWN_COUNTER_RELOAD_EN.
module d_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic             Pause,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             TC,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  // Busy and Done decode directly from the state flop, so they are register outputs.
  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  // Priority per edge: Clear, Load, Start, Pause, count.
  always_ff @(posedge CLK) begin
    if (!Clear) begin
      state <= IDLE;
      Q     <= '0;
      TC    <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      TC <= 1'b0;
      if (Load) begin
        state <= IDLE;
        Q     <= D;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload <= D;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (Start) begin
              if (Q == '0) begin
                state <= DONE;
                TC    <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (!Pause) begin
              if (Q == '0) begin
                // Only reachable in reload mode: the cycle after the terminal count.
`ifdef DOWN_COUNTER_RELOAD_EN
                if (reload != '0) begin
                  Q <= reload;
                end else begin
                  state <= DONE;
                end
`else
                state <= DONE;
`endif
              end else if (Q == WIDTH'(1)) begin
                Q  <= '0;
                TC <= 1'b1;
`ifndef DOWN_COUNTER_RELOAD_EN
                state <= DONE;
`endif
              end else begin
                Q <= Q - WIDTH'(1);
              end
            end
          end
          DONE: begin
            Q <= '0;
          end
          default: begin
            state <= IDLE;
            Q     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_d_down_counter.sv
// Directed testbench for d_down_counter; expectations follow DOWN_COUNTER_RELOAD_EN if defined.
module tb_d_down_counter;

  logic       CLK = 1'b0;
  logic       Clear, Load, Start, Pause;
  logic [7:0] D;
  logic [7:0] Q;
  logic       Busy, TC, Done;
  int         errors = 0;
  int         checks = 0;

  d_down_counter #(.WIDTH(8)) dut (
    .CLK(CLK), .Clear(Clear), .Load(Load), .D(D), .Start(Start), .Pause(Pause),
    .Q(Q), .Busy(Busy), .TC(TC), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] q, input logic b, input logic t, input logic d);
    checks++;
    if (Q !== q || Busy !== b || TC !== t || Done !== d) begin
      errors++;
      $display("FAIL %s: got Q=%h Busy=%b TC=%b Done=%b, expected Q=%h Busy=%b TC=%b Done=%b",
               name, Q, Busy, TC, Done, q, b, t, d);
    end
  endtask

  task automatic load(input logic [7:0] v);
    Load = 1'b1; D = v; step(); Load = 1'b0;
  endtask

  task automatic test_reset();
    Clear = 1'b0; Load = 1'b0; Start = 1'b0; Pause = 1'b0; D = 8'h00;
    step();
    chk("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    Load = 1'b1; D = 8'h55; Start = 1'b1;
    step();
    chk("clear_over_load", 8'h00, 1'b0, 1'b0, 1'b0);
    Load = 1'b0; Start = 1'b0; Clear = 1'b1;
  endtask

  task automatic test_clear_mid_run();
    load(8'h40);
    Start = 1'b1; step(); Start = 1'b0;
    chk("clear_run_start", 8'h40, 1'b1, 1'b0, 1'b0);
    repeat (9) step();
    chk("clear_run_at37", 8'h37, 1'b1, 1'b0, 1'b0);
    Clear = 1'b0; step(); Clear = 1'b1;
    chk("clear_mid_run", 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_count();
    load(8'h03);
    chk("count_load", 8'h03, 1'b0, 1'b0, 1'b0);
    Start = 1'b1; step(); Start = 1'b0;
    chk("count_start", 8'h03, 1'b1, 1'b0, 1'b0);
    step(); chk("count_q2", 8'h02, 1'b1, 1'b0, 1'b0);
    step(); chk("count_q1", 8'h01, 1'b1, 1'b0, 1'b0);
    step();
`ifdef DOWN_COUNTER_RELOAD_EN
    chk("count_tc", 8'h00, 1'b1, 1'b1, 1'b0);
    step(); chk("count_reloaded", 8'h03, 1'b1, 1'b0, 1'b0);
`else
    chk("count_tc", 8'h00, 1'b0, 1'b1, 1'b1);
    step(); chk("count_done_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    Start = 1'b1; Pause = 1'b1; step(); Start = 1'b0; Pause = 1'b0;
    chk("done_ignores_start", 8'h00, 1'b0, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_pause();
    int tcs = 0;
    load(8'h05);
    Start = 1'b1; step(); Start = 1'b0;
    step(); chk("pause_q4", 8'h04, 1'b1, 1'b0, 1'b0);
    Pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("pause_hold", 8'h04, 1'b1, 1'b0, 1'b0);
    end
    Pause = 1'b0;
    step(); chk("pause_resume", 8'h03, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (TC === 1'b1) tcs++;
    end
    checks++;
    if (tcs != 1) begin
      errors++;
      $display("FAIL pause_tc_count: got %0d pulses, expected 1", tcs);
    end
  endtask

  task automatic test_zero();
    load(8'h00);
    Start = 1'b1; step();
    chk("zero_tc", 8'h00, 1'b0, 1'b1, 1'b1);
    step(); Start = 1'b0;
    chk("zero_start_ignored", 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_load_start();
    Load = 1'b1; D = 8'h09; Start = 1'b1; step(); Load = 1'b0;
    chk("load_wins", 8'h09, 1'b0, 1'b0, 1'b0);
    step(); chk("start_after_load", 8'h09, 1'b1, 1'b0, 1'b0);
    step(); chk("start_in_run_ignored", 8'h08, 1'b1, 1'b0, 1'b0);
    Start = 1'b0;
    load(8'h02);
    chk("load_in_run", 8'h02, 1'b0, 1'b0, 1'b0);
    Pause = 1'b1; step(); Pause = 1'b0;
    chk("pause_in_idle", 8'h02, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reload();
    load(8'h02);
    Start = 1'b1; step(); Start = 1'b0;
    chk("reload_start", 8'h02, 1'b1, 1'b0, 1'b0);
    step(); chk("reload_q1", 8'h01, 1'b1, 1'b0, 1'b0);
    step();
`ifdef DOWN_COUNTER_RELOAD_EN
    chk("reload_tc1", 8'h00, 1'b1, 1'b1, 1'b0);
    step(); chk("reload_back", 8'h02, 1'b1, 1'b0, 1'b0);
    step(); chk("reload_q1b", 8'h01, 1'b1, 1'b0, 1'b0);
    step(); chk("reload_tc2", 8'h00, 1'b1, 1'b1, 1'b0);
    Pause = 1'b1; step(); Pause = 1'b0;
    chk("reload_deferred", 8'h00, 1'b1, 1'b0, 1'b0);
    step(); chk("reload_after_pause", 8'h02, 1'b1, 1'b0, 1'b0);
`else
    chk("noreload_tc", 8'h00, 1'b0, 1'b1, 1'b1);
    step(); chk("noreload_done", 8'h00, 1'b0, 1'b0, 1'b1);
`endif
  endtask

  initial begin
    test_reset();
    test_clear_mid_run();
    test_count();
    test_pause();
    test_zero();
    test_load_start();
    test_reload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d_down_counter.md
D_DOWN_COUNTER -- requirements
Module: d_down_counter

Interface
REQ-001 Parameter: WIDTH, 8, counter width in bits; all arithmetic is modulo 2^WIDTH.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: Clear  input  1  reset, synchronous, active-low; sampled on rising CLK.
REQ-004 Port: Load  input  1  parallel-load strobe.
REQ-005 Port: D  input  WIDTH  load value.
REQ-006 Port: Start  input  1  begin counting from current Q.
REQ-007 Port: Pause  input  1  hold count while high (RUN only).
REQ-008 Port: Q  output  WIDTH  current count, registered.
REQ-009 Port: Busy  output  1  high while in RUN, registered.
REQ-010 Port: TC  output  1  terminal-count pulse, one cycle, registered.
REQ-011 Port: Done  output  1  high while in DONE, registered.

Function
REQ-012 FSM states IDLE, RUN, DONE; Busy = (state==RUN), Done = (state==DONE).
REQ-013 Priority per edge: Clear > Load > Start > Pause > count.
REQ-014 Load=1 in any state: Q<=D, state<=IDLE, TC<=0, on the next edge.
REQ-015 IDLE, Start=1, Q!=0: state<=RUN; Q unchanged on that edge; first decrement on the following edge.
REQ-016 IDLE, Start=1, Q==0: state<=DONE, TC<=1 for one cycle.
REQ-017 RUN, Pause=1: Q, state held; TC=0.
REQ-018 RUN, Pause=0, Q>1: Q<=Q-1.
REQ-019 RUN, Pause=0, Q==1: Q<=0, TC<=1 (same edge), state<=DONE (unless REQ-026 applies).
REQ-020 Q never decrements below 0; no underflow wrap in any state.
REQ-021 DONE: Q held at 0; Start and Pause ignored; exit only via Load or Clear.
REQ-022 Start in RUN and Pause in IDLE/DONE have no effect.
REQ-023 Simultaneous Load and Start: Load wins; Start ignored that cycle.
REQ-024 TC is high for exactly one cycle per terminal event, never two consecutive cycles from one event.

Reset
REQ-025 Clear=0 at a rising edge: Q<=0, state<=IDLE, Busy=0, TC=0, Done=0, reload register<=0; applies mid-count, overriding Load/Start.

Configuration
REQ-026 Macro DOWN_COUNTER_RELOAD_EN defined: reload register captures D on every Load; in RUN on the edge after TC (Q==0, Pause=0), Q<=reload value and state stays RUN if reload!=0, else state<=DONE; Pause=1 while Q==0 in RUN holds Q=0 and defers reload; period = reload+1 cycles.
REQ-027 Macro not defined: no reload register; REQ-019 transition to DONE is unconditional.

Verification
REQ-028 Clear=0 one edge during RUN with Q=0x37 -> next cycle Q=0x00, Busy=0, Done=0, TC=0.
REQ-029 Load D=0x03, Start, no Pause -> Q: 03,03,02,01,00; TC=1 only in cycle Q first =00; Done=1 thereafter; Busy=0.
REQ-030 Load D=0x05, Start, Pause=1 for 3 cycles when Q=0x04 -> Q holds 04 three cycles, then resumes 03; TC still single pulse at 00.
REQ-031 Load D=0x00, Start -> next cycle TC=1, Done=1, Q=00; subsequent Start ignored.
REQ-032 Load D=0x09 and Start same cycle -> Q=09, state IDLE, Busy=0; Start next cycle then counts.
REQ-033 With DOWN_COUNTER_RELOAD_EN, Load D=0x02, Start -> Q: 02,02,01,00,02,01,00,...; TC every 3 cycles; Busy stays 1; without macro, Done after first 00.
